banded_traceback_walker: RTL

BANDED_TRACEBACK_WALKER -- requirements
Module: banded_traceback_walker

---
 rtl/banded_traceback_walker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/banded_traceback_walker.sv
// Banded Smith-Waterman traceback walker: follows per-PE pointer memories
// from the bottom-right cell and emits aligned (R, Q) symbol pairs.
module banded_traceback_walker #(
    parameter int B = 4,
    parameter int L = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_traceback,
    input  logic [3*L-1:0] R_sub,
    input  logic [3*L-1:0] Q_sub,
    input  logic [7:0]     rel_pos,
    output logic [1:0]     pe_id,
    output logic [7:0]     addr,
    output logic [2:0]     out_r,
    output logic [2:0]     out_q,
    output logic           out_valid,
    output logic [7:0]     pair_count,
    output logic           finish,
    output logic           band_err
);

    typedef enum logic [1:0] {IDLE, REQ, EVAL, DONE} state_t;

    localparam logic [1:0] D_END  = 2'b00;
    localparam logic [1:0] D_DIAG = 2'b01;
    localparam logic [1:0] D_UP   = 2'b10;
    localparam logic [1:0] D_LEFT = 2'b11;
    localparam logic [2:0] GAP    = 3'b100;
    localparam logic [7:0] MAX_PAIRS = 8'(2 * L - 1);

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [7:0] j_q, j_d;
    logic [1:0] pe_id_q, pe_id_d;
    logic [7:0] addr_q, addr_d;
    logic [2:0] out_r_q, out_r_d;
    logic [2:0] out_q_q, out_q_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] pair_count_q, pair_count_d;
    logic       finish_q, finish_d;
    logic       band_err_q, band_err_d;

    logic       step_i, step_j, under, off_band;
    logic [2:0] r_sym, q_sym;
    logic [7:0] cnt_new;
    int         pe_new;
    logic       unused_rel;

    // Only the direction code is meaningful in the pointer word.
    assign unused_rel = ^rel_pos[7:2];

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        j_d          = j_q;
        pe_id_d      = pe_id_q;
        addr_d       = addr_q;
        out_r_d      = out_r_q;
        out_q_d      = out_q_q;
        out_valid_d  = 1'b0;
        pair_count_d = pair_count_q;
        finish_d     = finish_q;
        band_err_d   = band_err_q;

        r_sym = 3'b000;
        q_sym = 3'b000;
        for (int k = 0; k < L; k++) begin
            if (addr_q == 8'(k)) r_sym = R_sub[3*k +: 3];
            if (j_q == 8'(k))    q_sym = Q_sub[3*k +: 3];
        end

        step_i = (dir_q == D_DIAG) || (dir_q == D_UP);
        step_j = (dir_q == D_DIAG) || (dir_q == D_LEFT);
        under  = (step_i && addr_q == 8'd0) || (step_j && j_q == 8'd0);

        // UP moves toward higher PEs, LEFT toward lower, DIAG stays.
        pe_new = int'(pe_id_q);
        if (dir_q == D_UP)   pe_new = pe_new + 1;
        if (dir_q == D_LEFT) pe_new = pe_new - 1;
        off_band = (pe_new < 0) || (pe_new > B - 1);
        cnt_new  = pair_count_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (start_traceback) begin
                    state_d      = REQ;
                    j_d          = 8'(L - 1);
                    pe_id_d      = 2'(B / 2);
                    addr_d       = 8'(L - 1);
                    pair_count_d = 8'd0;
                    band_err_d   = 1'b0;
                end
            end
            REQ: begin
                dir_d   = rel_pos[1:0];
                state_d = EVAL;
            end
            EVAL: begin
                if (dir_q == D_END) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end else begin
                    out_r_d      = step_i ? r_sym : GAP;
                    out_q_d      = step_j ? q_sym : GAP;
                    out_valid_d  = 1'b1;
                    pair_count_d = cnt_new;
                    band_err_d   = off_band;
                    if (!under && !off_band) begin
                        pe_id_d = pe_new[1:0];
                        addr_d  = addr_q - 8'(step_i);
                        j_d     = j_q - 8'(step_j);
                    end
                    if (under || off_band || cnt_new == MAX_PAIRS) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                if (!start_traceback) begin
                    state_d  = IDLE;
                    finish_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dir_q        <= D_END;
            j_q          <= 8'd0;
            pe_id_q      <= 2'd0;
            addr_q       <= 8'd0;
            out_r_q      <= 3'd0;
            out_q_q      <= 3'd0;
            out_valid_q  <= 1'b0;
            pair_count_q <= 8'd0;
            finish_q     <= 1'b0;
            band_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            j_q          <= j_d;
            pe_id_q      <= pe_id_d;
            addr_q       <= addr_d;
            out_r_q      <= out_r_d;
            out_q_q      <= out_q_d;
            out_valid_q  <= out_valid_d;
            pair_count_q <= pair_count_d;
            finish_q     <= finish_d;
            band_err_q   <= band_err_d;
        end
    end

    assign pe_id      = pe_id_q;
    assign addr       = addr_q;
    assign out_r      = out_r_q;
    assign out_q      = out_q_q;
    assign out_valid  = out_valid_q;
    assign pair_count = pair_count_q;
    assign finish     = finish_q;
    assign band_err   = band_err_q;

endmodule
